// File: rtl/datapath_pipelined.sv
// Two-stage register-file / function-unit datapath: EX (read, MUX B, FU, flags)
// and WB (MUX D, register write) with write-back-to-read forwarding.
module datapath_pipelined #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned RA_W  = 3
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          cw_valid,
  input  logic [3*RA_W+6:0]             control_word,
  input  logic [WIDTH-1:0]              constant_in,
  input  logic [WIDTH-1:0]              Data_in,
  output logic [WIDTH-1:0]              Address_out,
  output logic [WIDTH-1:0]              Data_out,
  output logic                          wb_valid,
  output logic                          V,
  output logic                          C,
  output logic                          N,
  output logic                          Z,
  output logic [(2**RA_W)*WIDTH-1:0]    rf_flat
);

  localparam int unsigned NREG = 2**RA_W;

  // Control word fields: {DA, AA, BA, MB, FS[3:0], MD, RW}
  logic            w_rw;
  logic            w_md;
  logic [3:0]      w_fs;
  logic            w_mb;
  logic [RA_W-1:0] w_ba;
  logic [RA_W-1:0] w_aa;
  logic [RA_W-1:0] w_da;

  assign w_rw = control_word[0];
  assign w_md = control_word[1];
  assign w_fs = control_word[5:2];
  assign w_mb = control_word[6];
  assign w_ba = control_word[7 +: RA_W];
  assign w_aa = control_word[7+RA_W +: RA_W];
  assign w_da = control_word[7+2*RA_W +: RA_W];

  logic [WIDTH-1:0] r_rf [NREG];
  logic             r_wb_valid;
  logic             r_wb_rw;
  logic             r_wb_md;
  logic [RA_W-1:0]  r_wb_da;
  logic [WIDTH-1:0] r_wb_f;
  logic [WIDTH-1:0] r_addr;
  logic [WIDTH-1:0] r_dout;
  logic             r_v;
  logic             r_c;
  logic             r_n;
  logic             r_z;

  // The word in WB supplies readers directly so dependent words need no stall
  logic             w_wb_we;
  logic [WIDTH-1:0] w_wb_data;
  logic [WIDTH-1:0] w_rd_a;
  logic [WIDTH-1:0] w_rd_b;
  logic [WIDTH-1:0] w_bus_a;
  logic [WIDTH-1:0] w_bus_b;

  assign w_wb_we   = r_wb_valid & r_wb_rw;
  assign w_wb_data = r_wb_md ? Data_in : r_wb_f;
  assign w_rd_a    = (w_wb_we && (r_wb_da == w_aa)) ? w_wb_data : r_rf[w_aa];
  assign w_rd_b    = (w_wb_we && (r_wb_da == w_ba)) ? w_wb_data : r_rf[w_ba];
  assign w_bus_a   = w_rd_a;
  assign w_bus_b   = w_mb ? constant_in : w_rd_b;

  // Function unit; FS 0-7 share one adder whose second operand and carry-in vary
  logic [WIDTH-1:0] w_add_op;
  logic             w_add_cin;
  logic [WIDTH:0]   w_sum;
  logic [WIDTH-1:0] w_f;
  logic             w_c;
  logic             w_v;

  always_comb begin
    w_add_op  = '0;
    w_add_cin = 1'b0;
    case (w_fs)
      4'h1:    w_add_cin = 1'b1;
      4'h2:    w_add_op  = w_bus_b;
      4'h3: begin
        w_add_op  = w_bus_b;
        w_add_cin = 1'b1;
      end
      4'h4:    w_add_op  = ~w_bus_b;
      4'h5: begin
        w_add_op  = ~w_bus_b;
        w_add_cin = 1'b1;
      end
      4'h6:    w_add_op  = '1;
      default: w_add_op  = '0;
    endcase
  end

  assign w_sum = {1'b0, w_bus_a} + {1'b0, w_add_op} + {{WIDTH{1'b0}}, w_add_cin};

  always_comb begin
    w_f = '0;
    w_c = 1'b0;
    w_v = 1'b0;
    if (!w_fs[3]) begin
      w_f = w_sum[WIDTH-1:0];
      w_c = w_sum[WIDTH];
      w_v = (w_bus_a[WIDTH-1] == w_add_op[WIDTH-1]) &&
            (w_sum[WIDTH-1] != w_bus_a[WIDTH-1]);
    end else begin
      case (w_fs)
        4'h8: w_f = w_bus_a & w_bus_b;
        4'h9: w_f = w_bus_a | w_bus_b;
        4'hA: w_f = w_bus_a ^ w_bus_b;
        4'hB: w_f = ~w_bus_a;
        4'hC: w_f = w_bus_b;
        4'hD: begin
          w_f = w_bus_b >> 1;
          w_c = w_bus_b[0];
        end
        4'hE: begin
          w_f = w_bus_b << 1;
          w_c = w_bus_b[WIDTH-1];
        end
        default: w_f = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < int'(NREG); i++) r_rf[i] <= '0;
      r_wb_valid <= 1'b0;
      r_wb_rw    <= 1'b0;
      r_wb_md    <= 1'b0;
      r_wb_da    <= '0;
      r_wb_f     <= '0;
      r_addr     <= '0;
      r_dout     <= '0;
      r_v        <= 1'b0;
      r_c        <= 1'b0;
      r_n        <= 1'b0;
      r_z        <= 1'b0;
    end else begin
      if (w_wb_we) r_rf[r_wb_da] <= w_wb_data;
      r_wb_valid <= cw_valid;
      if (cw_valid) begin
        r_wb_rw <= w_rw;
        r_wb_md <= w_md;
        r_wb_da <= w_da;
        r_wb_f  <= w_f;
        r_addr  <= w_bus_a;
        r_dout  <= w_bus_b;
        // Loads leave the flags alone; only FU results set them
        if (!w_md) begin
          r_v <= w_v;
          r_c <= w_c;
          r_n <= w_f[WIDTH-1];
          r_z <= (w_f == '0);
        end
      end
    end
  end

  always_comb begin
    rf_flat = '0;
    for (int i = 0; i < int'(NREG); i++) rf_flat[i*WIDTH +: WIDTH] = r_rf[i];
  end

  assign Address_out = r_addr;
  assign Data_out    = r_dout;
  assign wb_valid    = r_wb_valid;
  assign V           = r_v;
  assign C           = r_c;
  assign N           = r_n;
  assign Z           = r_z;

endmodule

// File: tb/tb_datapath_pipelined.sv
// Bench for datapath_pipelined: directed scenarios plus random control words
// checked against an arithmetic reference model; also a WIDTH=16 instance.
module tb_datapath_pipelined;

  logic        clk = 1'b0;
  logic        reset;
  logic        cw_valid;
  logic [15:0] control_word;
  logic [7:0]  constant_in;
  logic [7:0]  Data_in;
  logic [7:0]  Address_out;
  logic [7:0]  Data_out;
  logic        wb_valid;
  logic        V, C, N, Z;
  logic [63:0] rf_flat;

  logic         cw_valid16;
  logic [18:0]  control_word16;
  logic [15:0]  constant_in16;
  logic [15:0]  Data_in16;
  logic [15:0]  Address_out16;
  logic [15:0]  Data_out16;
  logic         wb_valid16;
  logic         V16, C16, N16, Z16;
  logic [255:0] rf_flat16;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  datapath_pipelined #(.WIDTH(8), .RA_W(3)) dut (
    .clk(clk), .reset(reset), .cw_valid(cw_valid), .control_word(control_word),
    .constant_in(constant_in), .Data_in(Data_in), .Address_out(Address_out),
    .Data_out(Data_out), .wb_valid(wb_valid), .V(V), .C(C), .N(N), .Z(Z),
    .rf_flat(rf_flat)
  );

  datapath_pipelined #(.WIDTH(16), .RA_W(4)) dut16 (
    .clk(clk), .reset(reset), .cw_valid(cw_valid16), .control_word(control_word16),
    .constant_in(constant_in16), .Data_in(Data_in16), .Address_out(Address_out16),
    .Data_out(Data_out16), .wb_valid(wb_valid16), .V(V16), .C(C16), .N(N16), .Z(Z16),
    .rf_flat(rf_flat16)
  );

  // Reference model: architectural registers plus the one word awaiting write-back
  logic [7:0] m_rf [8];
  logic       p_valid, p_rw, p_md;
  logic [2:0] p_da;
  logic [7:0] p_f;
  logic [7:0] m_addr, m_dout;
  logic       m_v, m_c, m_n, m_z;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] mkcw(input int da, input int aa, input int ba,
                                       input int mb, input int fs, input int md, input int rw);
    return {3'(da), 3'(aa), 3'(ba), 1'(mb), 4'(fs), 1'(md), 1'(rw)};
  endfunction

  function automatic logic [7:0] reg8(input int i);
    logic [63:0] t;
    t = rf_flat;
    return t[i*8 +: 8];
  endfunction

  function automatic logic [63:0] model_flat();
    logic [63:0] t;
    for (int i = 0; i < 8; i++) t[i*8 +: 8] = m_rf[i];
    return t;
  endfunction

  function automatic logic [7:0] fwd(input logic [2:0] x, input logic [7:0] din);
    if (p_valid && p_rw && p_da == x) return p_md ? din : p_f;
    return m_rf[x];
  endfunction

  // Function unit written as plain integer arithmetic on width-w values
  task automatic alu(input logic [3:0] fs, input longint unsigned a, input longint unsigned b,
                     input int w, output longint unsigned f, output bit c, output bit ov);
    longint unsigned mask, op, s;
    int cin;
    mask = (64'd1 << w) - 1;
    op = 0; cin = 0; c = 0; ov = 0; f = 0;
    if (fs < 8) begin
      case (fs)
        1: cin = 1;
        2: op = b;
        3: begin op = b; cin = 1; end
        4: op = ~b & mask;
        5: begin op = ~b & mask; cin = 1; end
        6: op = mask;
        default: op = 0;
      endcase
      s  = a + op + longint'(cin);
      f  = s & mask;
      c  = bit'((s >> w) & 1);
      ov = (((a >> (w-1)) & 1) == ((op >> (w-1)) & 1)) &&
           (((f >> (w-1)) & 1) != ((a >> (w-1)) & 1));
    end else begin
      case (fs)
        8:  f = a & b;
        9:  f = a | b;
        10: f = a ^ b;
        11: f = ~a & mask;
        12: f = b;
        13: begin f = b >> 1; c = bit'(b & 1); end
        14: begin f = (b << 1) & mask; c = bit'((b >> (w-1)) & 1); end
        default: f = 0;
      endcase
    end
  endtask

  // One clock: drive inputs, predict, then compare all outputs just after the edge
  task automatic step(input bit rst, input bit v, input logic [15:0] cw,
                      input logic [7:0] k, input logic [7:0] din);
    logic [2:0] da, aa, ba;
    logic mb, md, rw;
    logic [3:0] fs;
    longint unsigned a, b, f;
    bit c, ov;
    reset = rst; cw_valid = v; control_word = cw; constant_in = k; Data_in = din;
    {da, aa, ba, mb, fs, md, rw} = cw;
    a = longint'(fwd(aa, din));
    b = mb ? longint'(k) : longint'(fwd(ba, din));
    alu(fs, a, b, 8, f, c, ov);
    @(posedge clk);
    #1;
    if (rst) begin
      for (int i = 0; i < 8; i++) m_rf[i] = 8'h00;
      p_valid = 0; p_rw = 0; p_md = 0; p_da = 0; p_f = 0;
      m_addr = 0; m_dout = 0; m_v = 0; m_c = 0; m_n = 0; m_z = 0;
    end else begin
      if (p_valid && p_rw) m_rf[p_da] = p_md ? din : p_f;
      p_valid = v;
      if (v) begin
        p_da = da; p_md = md; p_rw = rw; p_f = 8'(f);
        m_addr = 8'(a); m_dout = 8'(b);
        if (!md) begin
          m_v = ov; m_c = c; m_n = f[7]; m_z = (f == 0);
        end
      end
    end
    chk("rf_flat", rf_flat, model_flat());
    chk("Address_out", 64'(Address_out), 64'(m_addr));
    chk("Data_out", 64'(Data_out), 64'(m_dout));
    chk("flags_VCNZ", 64'({V, C, N, Z}), 64'({m_v, m_c, m_n, m_z}));
    chk("wb_valid", 64'(wb_valid), 64'(p_valid));
  endtask

  task automatic idle();
    step(0, 0, 16'h0, 8'h00, 8'h00);
  endtask

  logic [7:0] s_addr, s_dout, s_r1;
  logic [3:0] s_flags;

  initial begin
    reset = 1; cw_valid = 0; control_word = 0; constant_in = 0; Data_in = 0;
    cw_valid16 = 0; control_word16 = 0; constant_in16 = 0; Data_in16 = 0;
    p_valid = 0; p_rw = 0; p_md = 0; p_da = 0; p_f = 0;
    for (int i = 0; i < 8; i++) m_rf[i] = 8'h00;
    m_addr = 0; m_dout = 0; m_v = 0; m_c = 0; m_n = 0; m_z = 0;
    @(negedge clk);
    step(1, 0, 16'h0, 8'h00, 8'h00);
    step(1, 0, 16'h0, 8'h00, 8'h00);
    chk("reset_rf", rf_flat, 64'h0);
    chk("reset_flags", 64'({V, C, N, Z}), 64'h0);

    // Reset while a write sits in WB: that write must never land
    step(0, 1, mkcw(7, 0, 0, 1, 'hC, 0, 1), 8'h55, 8'h00);
    step(1, 0, 16'h0, 8'h00, 8'h00);
    idle();
    chk("dropped_write_R7", 64'(reg8(7)), 64'h0);
    chk("reset_wb_valid", 64'(wb_valid), 64'h0);

    // Constant load then dependent add via forwarding
    step(0, 1, mkcw(1, 0, 0, 1, 'hC, 0, 1), 8'h05, 8'h00);
    step(0, 1, mkcw(2, 1, 1, 0, 2, 0, 1), 8'h00, 8'h00);
    chk("fwd_busA_R1", 64'(Address_out), 64'h05);
    chk("R1_after_2_edges", 64'(reg8(1)), 64'h05);
    idle();
    chk("R2_sum", 64'(reg8(2)), 64'h0A);

    // Subtract flags
    step(0, 1, mkcw(3, 0, 0, 1, 'hC, 0, 1), 8'h80, 8'h00);
    step(0, 1, mkcw(4, 0, 0, 1, 'hC, 0, 1), 8'h01, 8'h00);
    step(0, 1, mkcw(7, 3, 4, 0, 5, 0, 1), 8'h00, 8'h00);
    chk("sub_flags_VCNZ", 64'({V, C, N, Z}), 64'b1100);
    step(0, 1, mkcw(0, 1, 1, 0, 5, 0, 1), 8'h00, 8'h00);
    chk("R7_7F", 64'(reg8(7)), 64'h7F);
    chk("sub_zero_VCNZ", 64'({V, C, N, Z}), 64'b0101);

    // Load path with forwarding of Data_in
    step(0, 1, mkcw(5, 2, 0, 0, 0, 1, 1), 8'h00, 8'h00);
    chk("load_addr_R2", 64'(Address_out), 64'h0A);
    chk("load_flags_hold", 64'({V, C, N, Z}), 64'b0101);
    step(0, 1, mkcw(6, 5, 0, 0, 0, 0, 1), 8'h00, 8'h3C);
    chk("load_fwd", 64'(Address_out), 64'h3C);
    chk("R5_loaded", 64'(reg8(5)), 64'h3C);

    // Shifts
    step(0, 1, mkcw(1, 0, 0, 1, 'hE, 0, 1), 8'h81, 8'h00);
    chk("shl_VCNZ", 64'({V, C, N, Z}), 64'b0100);
    step(0, 1, mkcw(1, 0, 0, 1, 'hD, 0, 1), 8'h81, 8'h00);
    chk("shl_result_R1", 64'(reg8(1)), 64'h02);
    chk("shr_VCNZ", 64'({V, C, N, Z}), 64'b0100);
    step(0, 1, mkcw(1, 0, 0, 1, 'hE, 0, 1), 8'h00, 8'h00);
    chk("shr_result_R1", 64'(reg8(1)), 64'h40);
    chk("shl_zero_VCNZ", 64'({V, C, N, Z}), 64'b0001);

    // Bubbles hold outputs; RW=0 word neither writes nor forwards
    idle();
    s_addr = Address_out; s_dout = Data_out; s_flags = {V, C, N, Z}; s_r1 = m_rf[1];
    for (int i = 0; i < 3; i++) begin
      step(0, 0, mkcw(2, 3, 4, 0, 2, 0, 1), 8'hAA, 8'h00);
      chk("bubble_hold", 64'({Address_out, Data_out, V, C, N, Z}), 64'({s_addr, s_dout, s_flags}));
    end
    step(0, 1, mkcw(1, 0, 0, 1, 'hC, 0, 0), 8'h99, 8'h00);
    step(0, 1, mkcw(2, 1, 0, 0, 0, 0, 1), 8'h00, 8'h00);
    chk("rw0_no_fwd", 64'(Address_out), 64'(s_r1));
    idle();
    chk("rw0_no_write", 64'(reg8(1)), 64'(s_r1));

    // Random control words against the model
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 29) == 0, $urandom_range(0, 3) != 0,
           16'($urandom), 8'($urandom), 8'($urandom));
    end

    // WIDTH=16: 0xFFFF + 1 wraps to zero with carry
    reset = 0; cw_valid = 0;
    control_word16 = {4'd1, 4'd0, 4'd0, 1'b1, 4'hC, 1'b0, 1'b1};
    constant_in16 = 16'hFFFF; cw_valid16 = 1;
    @(posedge clk); #1;
    control_word16 = {4'd2, 4'd1, 4'd0, 1'b0, 4'h1, 1'b0, 1'b1};
    @(posedge clk); #1;
    chk("w16_fwd_busA", 64'(Address_out16), 64'hFFFF);
    chk("w16_inc_VCNZ", 64'({V16, C16, N16, Z16}), 64'b0101);
    cw_valid16 = 0;
    @(posedge clk); #1;
    chk("w16_R1", 64'(rf_flat16[16 +: 16]), 64'hFFFF);
    chk("w16_R2", 64'(rf_flat16[32 +: 16]), 64'h0);
    chk("w16_wb_valid", 64'(wb_valid16), 64'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
